// File: rtl/rx_chk_pkg.sv
// Shared types for the RX AXI4-Stream frame checker: FSM states, frame
// classification codes and the frame-length width.
package rx_chk_pkg;

  localparam int LEN_W   = 16;
  localparam int NUM_CLS = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_DRAIN
  } state_e;

  typedef enum logic [2:0] {
    CLS_GOOD,
    CLS_CRC,
    CLS_RUNT,
    CLS_OVERSIZE,
    CLS_KEEP
  } cls_e;

endpackage

// File: rtl/rx_chk_beat_decode.sv
// Combinational per-beat decode: byte popcount, tkeep shape check and
// tdata with disabled bytes zeroed.
module rx_chk_beat_decode #(
  parameter int  DATA_W = 64,
  localparam int KEEP_W = DATA_W / 8,
  localparam int PC_W   = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tlast,
  output logic [PC_W-1:0]   o_popcnt,
  output logic              o_keep_ok,
  output logic [DATA_W-1:0] o_masked
);

  logic [KEEP_W-1:0] w_keep_inc;

  always_comb begin
    o_popcnt = '0;
    for (int i = 0; i < KEEP_W; i++) o_popcnt = o_popcnt + PC_W'(i_tkeep[i]);
  end

  // Last beat must be a nonzero run of ones from bit 0: adding one to such a
  // mask clears every set bit.
  assign w_keep_inc = i_tkeep + KEEP_W'(1);
  assign o_keep_ok  = i_tlast ? (i_tkeep[0] && ((i_tkeep & w_keep_inc) == '0))
                              : (&i_tkeep);

  for (genvar g = 0; g < KEEP_W; g++) begin : g_mask
    assign o_masked[g*8 +: 8] = i_tdata[g*8 +: 8] & {8{i_tkeep[g]}};
  end

endmodule

// File: rtl/rx_axis_frame_chk.sv
// Passive checker for the MAC RX AXI4-Stream: classifies each frame, keeps
// saturating counters. Optional frame signature under RX_CHK_SIGNATURE_EN.
module rx_axis_frame_chk
  import rx_chk_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int KEEP_W        = DATA_W / 8,
  parameter int MIN_BYTES     = 60,
  parameter int MAX_BYTES     = 1514,
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 100
) (
  input  logic              clk,
  input  logic              rx_axis_aresetn,
  input  logic [DATA_W-1:0] rx_axis_tdata,
  input  logic [KEEP_W-1:0] rx_axis_tkeep,
  input  logic              rx_axis_tvalid,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  input  logic              clr_stats,
  output logic              frame_done,
  output logic              frame_good,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  good_frames,
  output logic [CNT_W-1:0]  crc_err_frames,
  output logic [CNT_W-1:0]  runt_frames,
  output logic [CNT_W-1:0]  oversize_frames,
  output logic [CNT_W-1:0]  keep_err_frames,
  output logic              stall_err,
  output logic [DATA_W-1:0] frame_sig
);

  localparam int PC_W = $clog2(KEEP_W + 1);
  localparam int ST_W = $clog2(STALL_TIMEOUT + 1);

  state_e             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic               r_keep_err;
  logic [ST_W-1:0]    r_stall;
  logic               r_frame_done, r_frame_good, r_stall_err;
  logic [LEN_W-1:0]   r_frame_len;
  logic [NUM_CLS-1:0][CNT_W-1:0] r_cnt;

  logic [PC_W-1:0]    w_popcnt;
  logic               w_keep_ok;
  logic [DATA_W-1:0]  w_masked;
  logic               w_start, w_acc, w_fire, w_timeout;
  logic [LEN_W-1:0]   w_base_len, w_len_nxt;
  logic [LEN_W:0]     w_sum;
  logic               w_kerr_nxt;
  cls_e               w_cls;

  rx_chk_beat_decode #(.DATA_W(DATA_W)) u_dec (
    .i_tkeep   (rx_axis_tkeep),
    .i_tdata   (rx_axis_tdata),
    .i_tlast   (rx_axis_tlast),
    .o_popcnt  (w_popcnt),
    .o_keep_ok (w_keep_ok),
    .o_masked  (w_masked)
  );

  assign w_start    = rx_axis_tvalid && (r_state == ST_IDLE);
  assign w_acc      = rx_axis_tvalid && (r_state != ST_DRAIN);
  assign w_fire     = w_acc && rx_axis_tlast;
  assign w_timeout  = (r_state == ST_BODY) && !rx_axis_tvalid &&
                      (r_stall == ST_W'(STALL_TIMEOUT - 1));

  // A frame's first beat folds into a zeroed accumulator in the same cycle.
  assign w_base_len = w_start ? '0 : r_len;
  assign w_sum      = {1'b0, w_base_len} + (LEN_W+1)'(w_popcnt);
  assign w_len_nxt  = w_sum[LEN_W] ? '1 : w_sum[LEN_W-1:0];
  assign w_kerr_nxt = (!w_start && r_keep_err) || !w_keep_ok;

  always_comb begin
    w_cls = CLS_GOOD;
    if (w_kerr_nxt)                             w_cls = CLS_KEEP;
    else if (!rx_axis_tuser)                    w_cls = CLS_CRC;
    else if (w_len_nxt < LEN_W'(MIN_BYTES))     w_cls = CLS_RUNT;
    else if (w_len_nxt > LEN_W'(MAX_BYTES))     w_cls = CLS_OVERSIZE;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (rx_axis_tvalid && !rx_axis_tlast) w_state_nxt = ST_BODY;
      ST_BODY:  if (rx_axis_tvalid && rx_axis_tlast)  w_state_nxt = ST_IDLE;
                else if (w_timeout)                   w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (rx_axis_tvalid && rx_axis_tlast)  w_state_nxt = ST_IDLE;
      default:                                        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_keep_err <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_len      <= w_len_nxt;
        r_keep_err <= w_kerr_nxt;
      end
      if ((r_state == ST_BODY) && !rx_axis_tvalid) r_stall <= r_stall + 1'b1;
      else                                         r_stall <= '0;
    end
  end

  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      r_frame_done <= 1'b0;
      r_frame_good <= 1'b0;
      r_frame_len  <= '0;
      r_stall_err  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_frame_done <= w_fire;
      if (w_fire) begin
        r_frame_good <= (w_cls == CLS_GOOD);
        r_frame_len  <= w_len_nxt;
      end
      if (w_timeout)      r_stall_err <= 1'b1;
      else if (clr_stats) r_stall_err <= 1'b0;
      // Clear and a same-cycle classification: the frame lands on a zeroed counter.
      for (int i = 0; i < NUM_CLS; i++) begin
        if (clr_stats)
          r_cnt[i] <= (w_fire && (w_cls == cls_e'(i))) ? CNT_W'(1) : '0;
        else if (w_fire && (w_cls == cls_e'(i)) && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign frame_done      = r_frame_done;
  assign frame_good      = r_frame_good;
  assign frame_len       = r_frame_len;
  assign stall_err       = r_stall_err;
  assign good_frames     = r_cnt[CLS_GOOD];
  assign crc_err_frames  = r_cnt[CLS_CRC];
  assign runt_frames     = r_cnt[CLS_RUNT];
  assign oversize_frames = r_cnt[CLS_OVERSIZE];
  assign keep_err_frames = r_cnt[CLS_KEEP];

`ifdef RX_CHK_SIGNATURE_EN
  logic [DATA_W-1:0] r_sig, r_frame_sig, w_sig_base, w_sig_nxt;

  assign w_sig_base = w_start ? '0 : r_sig;
  assign w_sig_nxt  = {w_sig_base[DATA_W-2:0], w_sig_base[DATA_W-1]} ^ w_masked;

  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      r_sig       <= '0;
      r_frame_sig <= '0;
    end else begin
      if (w_acc)  r_sig       <= w_sig_nxt;
      if (w_fire) r_frame_sig <= w_sig_nxt;
    end
  end

  assign frame_sig = r_frame_sig;
`else
  assign frame_sig = '0;
`endif

endmodule

// File: tb/tb_rx_axis_frame_chk.sv
// Bench for rx_axis_frame_chk: directed table, hand-written stall/clear/reset
// sequences and random frames checked against a frame-level reference model.
module tb_rx_axis_frame_chk;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic [KEEP_W-1:0] tkeep = '0;
  logic              tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, clr_stats = 1'b0;
  logic              frame_done, frame_good, stall_err;
  logic [15:0]       frame_len;
  logic [CNT_W-1:0]  good_frames, crc_err_frames, runt_frames, oversize_frames, keep_err_frames;
  logic [DATA_W-1:0] frame_sig;

  rx_axis_frame_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rx_axis_aresetn(rst_n), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .clr_stats(clr_stats), .frame_done(frame_done), .frame_good(frame_good),
    .frame_len(frame_len), .good_frames(good_frames), .crc_err_frames(crc_err_frames),
    .runt_frames(runt_frames), .oversize_frames(oversize_frames),
    .keep_err_frames(keep_err_frames), .stall_err(stall_err), .frame_sig(frame_sig)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  bit clr_seen = 0;
  bit fixed_data = 0;
  int mcnt[5];

  typedef struct {
    bit          good;
    int          len;
    int          cls;
    logic [63:0] sig;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  fk[$];
  logic [63:0] fd[$];

  typedef struct {
    int         len;
    bit         user;
    int         bad_mid;
    logic [7:0] last_force;
    bit         exp_good;
    int         exp_cls;
    int         exp_len;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int c);
    case (c)
      0: return int'(good_frames);
      1: return int'(crc_err_frames);
      2: return int'(runt_frames);
      3: return int'(oversize_frames);
      default: return int'(keep_err_frames);
    endcase
  endfunction

  // Frame-level reference: length, keep-shape legality and priority classification.
  function automatic exp_t model_frame(input bit user);
    exp_t e;
    int len = 0;
    bit kerr = 0;
    logic [63:0] s = '0, m;
    for (int b = 0; b < fk.size(); b++) begin
      for (int k = 0; k < 8; k++) if (fk[b][k]) len++;
      if (b < fk.size() - 1) begin
        if (fk[b] != 8'hFF) kerr = 1;
      end else if (!(fk[b] inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF})) begin
        kerr = 1;
      end
      for (int k = 0; k < 8; k++) m[k*8 +: 8] = fk[b][k] ? fd[b][k*8 +: 8] : 8'h00;
      s = {s[62:0], s[63]} ^ m;
    end
    if (len > 65535) len = 65535;
    e.len = len;
    if (kerr)           e.cls = 4;
    else if (!user)     e.cls = 1;
    else if (len < 60)  e.cls = 2;
    else if (len > 1514) e.cls = 3;
    else                e.cls = 0;
    e.good = (e.cls == 0);
`ifndef RX_CHK_SIGNATURE_EN
    s = '0;
`endif
    e.sig = s;
    e.due = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    clr_seen = clr_stats;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) mcnt[i] = 0;
    end else begin
      if (clr_seen) for (int i = 0; i < 5; i++) mcnt[i] = 0;
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.due);
          chk("mon_good", frame_good, e.good);
          chk("mon_len", frame_len, e.len);
          chk("mon_sig", frame_sig, e.sig);
          if (mcnt[e.cls] < CMAX) mcnt[e.cls]++;
        end
      end
      if (frame_done || clr_seen) begin
        chk("mon_good_frames", good_frames, mcnt[0]);
        chk("mon_crc_frames", crc_err_frames, mcnt[1]);
        chk("mon_runt_frames", runt_frames, mcnt[2]);
        chk("mon_oversize_frames", oversize_frames, mcnt[3]);
        chk("mon_keep_frames", keep_err_frames, mcnt[4]);
      end
    end
  end

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] k, input bit last, input bit user);
    tvalid = 1'b1; tkeep = k; tdata = {$urandom, $urandom}; tlast = last; tuser = user;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit user, input int bad_mid,
                            input logic [7:0] last_force, input int max_gap,
                            input int long_gap, input bit clr_last);
    int nb, rem;
    exp_t e;
    fk.delete();
    fd.delete();
    nb  = (len + 7) / 8;
    rem = len - 8 * (nb - 1);
    for (int b = 0; b < nb; b++) begin
      logic [7:0] k;
      k = 8'hFF;
      if (b == nb - 1) k = 8'hFF >> (8 - rem);
      if (b == bad_mid && b < nb - 1) k = 8'h7F;
      if (b == nb - 1 && last_force != 8'h00) k = last_force;
      fk.push_back(k);
      fd.push_back(fixed_data ? {32'(b), 32'hA5C3_0F1E} : {$urandom, $urandom});
    end
    e = model_frame(user);
    for (int b = 0; b < nb; b++) begin
      if (b > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      if (b == 3 && long_gap > 0) idle(long_gap);
      tvalid = 1'b1; tkeep = fk[b]; tdata = fd[b]; tlast = (b == nb - 1);
      tuser  = (b == nb - 1) ? user : 1'($urandom_range(0, 1));
      if (b == nb - 1) begin
        clr_stats = clr_last;
        e.due = cyc + 1;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      clr_stats = 1'b0;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    vec_t tv[$];
    int c0, len, nb;
    logic [63:0] s1;

    tv.push_back('{64,   1, -1, 8'h00, 1, 0, 64});
    tv.push_back('{61,   0, -1, 8'h00, 0, 1, 61});
    tv.push_back('{40,   1, -1, 8'h00, 0, 2, 40});
    tv.push_back('{1520, 1, -1, 8'h00, 0, 3, 1520});
    tv.push_back('{64,   0,  2, 8'h00, 0, 4, 63});
    tv.push_back('{61,   0, -1, 8'h05, 0, 4, 58});
    tv.push_back('{60,   1, -1, 8'h00, 1, 0, 60});
    tv.push_back('{59,   1, -1, 8'h00, 0, 2, 59});
    tv.push_back('{1514, 1, -1, 8'h00, 1, 0, 1514});
    tv.push_back('{1515, 1, -1, 8'h00, 0, 3, 1515});
    tv.push_back('{8,    1, -1, 8'h00, 0, 2, 8});
    tv.push_back('{4,    1, -1, 8'h00, 0, 2, 4});
    tv.push_back('{16,   1, -1, 8'h0E, 0, 4, 11});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_good", frame_good, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_counters", {good_frames, crc_err_frames, runt_frames, oversize_frames, keep_err_frames}, 0);
    chk("rst_stall_err", stall_err, 0);
    chk("rst_frame_sig", frame_sig, 0);
    rst_n = 1'b1;
    idle(2);

    foreach (tv[i]) begin
      c0 = cnt_of(tv[i].exp_cls);
      send_frame(tv[i].len, tv[i].user, tv[i].bad_mid, tv[i].last_force, 1, 0, 0);
      chk($sformatf("tbl%0d_done", i), frame_done, 1);
      chk($sformatf("tbl%0d_good", i), frame_good, tv[i].exp_good);
      chk($sformatf("tbl%0d_len", i), frame_len, tv[i].exp_len);
      chk($sformatf("tbl%0d_cnt", i), cnt_of(tv[i].exp_cls), (c0 < CMAX) ? c0 + 1 : CMAX);
      idle($urandom_range(0, 1));
    end

    // 99 idle cycles mid-frame stay just under the timeout.
    send_frame(64, 1, -1, 8'h00, 0, 99, 0);
    chk("gap99_good", frame_good, 1);
    chk("gap99_no_stall", stall_err, 0);
    idle(1);

    // 100 idle cycles: timeout, drain the rest, then a clean frame.
    for (int i = 0; i < 3; i++) beat(8'hFF, 0, 1);
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (i == 98) chk("stall_before_timeout", stall_err, 0);
    end
    chk("stall_at_timeout", stall_err, 1);
    for (int i = 0; i < 3; i++) beat(8'hFF, 0, 1);
    beat(8'h0F, 1, 1);
    idle(2);
    chk("drain_no_done", frame_done, 0);
    c0 = int'(good_frames);
    send_frame(64, 1, -1, 8'h00, 0, 0, 0);
    chk("after_drain_good", frame_good, 1);
    chk("after_drain_cnt", good_frames, (c0 < CMAX) ? c0 + 1 : CMAX);
    chk("stall_sticky", stall_err, 1);
    idle(1);

    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    chk("clr_counters", {good_frames, crc_err_frames, runt_frames, oversize_frames, keep_err_frames}, 0);
    chk("clr_stall_err", stall_err, 0);

    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(1, 1600);
      nb  = (len + 7) / 8;
      send_frame(len, ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb)) : -1,
                 ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 $urandom_range(0, 3), 0, 0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(64, 1, -1, 8'h00, 0, 0, 0);
    chk("pre_clr_good5", good_frames, 5);
    send_frame(64, 1, -1, 8'h00, 0, 0, 1);
    chk("clr_same_cycle_good", good_frames, 1);
    chk("clr_same_cycle_crc", crc_err_frames, 0);
    idle(1);

    send_frame(70000, 1, -1, 8'h00, 0, 0, 0);
    chk("len_saturate", frame_len, 16'hFFFF);
    chk("len_saturate_oversize", oversize_frames, 1);
    idle(1);

`ifdef RX_CHK_SIGNATURE_EN
    fixed_data = 1;
    send_frame(64, 1, -1, 8'h00, 0, 0, 0);
    s1 = frame_sig;
    chk("sig_nonzero", (s1 != 0), 1);
    idle(1);
    send_frame(64, 1, -1, 8'h00, 0, 0, 0);
    chk("sig_repeat", frame_sig, s1);
    fixed_data = 0;
    idle(1);
`else
    s1 = '0;
`endif

    // Reset mid-frame: stale beats must not leak into the next frame.
    for (int i = 0; i < 3; i++) beat(8'hFF, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_counters", {good_frames, crc_err_frames, runt_frames, oversize_frames, keep_err_frames}, 0);
    chk("midrst_len", frame_len, 0);
    idle(2);
    rst_n = 1'b1;
    send_frame(64, 1, -1, 8'h00, 0, 0, 0);
    chk("post_rst_len", frame_len, 64);
    chk("post_rst_good", good_frames, 1);

    idle(4);
    chk("exp_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rx_axis_frame_chk.md
# rx_axis_frame_chk

Passive, parametrised checker for the MAC RX AXI4-Stream output (no tready; it never backpressures). It runs in the RX user clock domain after the MAC. It validates every beat and every frame: tkeep shape, tuser CRC status, length bounds and mid-frame stalls. It keeps saturating per-category frame counters and emits a per-frame result strobe, and in simulation and hardware it replaces ad-hoc frame-checking logic.

## Interface
- DATA_W, 64: tdata width; multiple of 8, range 32..256.
- KEEP_W, DATA_W/8: derived; do not override.
- MIN_BYTES, 60: frames shorter than this are runts (FCS already stripped).
- MAX_BYTES, 1514: frames longer than this are oversize.
- CNT_W, 32: statistics counter width.
- STALL_TIMEOUT, 100: idle cycles allowed inside a frame; must be ≥ 1.

- clk  in  1  single clock; all logic on its rising edge.
- rx_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- rx_axis_tdata  in  DATA_W  beat data.
- rx_axis_tkeep  in  KEEP_W  byte enables.
- rx_axis_tvalid  in  1  beat valid.
- rx_axis_tlast  in  1  last beat of frame.
- rx_axis_tuser  in  1  1 = good CRC; sampled only on the tlast beat.
- clr_stats  in  1  synchronous clear of all counters and sticky flags.
- frame_done  out  1  one-cycle strobe per classified frame.
- frame_good  out  1  result of the frame being classified; valid with frame_done.
- frame_len  out  16  byte count of that frame, saturating at 0xFFFF.
- good_frames, crc_err_frames, runt_frames, oversize_frames, keep_err_frames  out  CNT_W each  per-category counters; each saturates at all-ones.
- stall_err  out  1  sticky; set when a frame times out.
- frame_sig  out  DATA_W  frame signature; 0 when the feature is compiled out.

All outputs reset to 0.

## Operation
- States:
  - IDLE: waiting for the first beat of a frame.
  - BODY: inside a frame.
  - DRAIN: discarding the rest of an aborted frame.
- IDLE:
  - A valid beat starts a frame: byte count and error bits clear, then this beat is accumulated.
  - With tlast on that beat, the frame is classified in the same cycle and the state stays IDLE.
  - Without tlast, go to BODY.
- BODY: each valid beat accumulates. A tlast beat classifies the frame and returns to IDLE.
- Beat check:
  - A non-last beat must have tkeep all-ones.
  - A last beat must have tkeep = 2^n−1 with 1 ≤ n ≤ KEEP_W.
  - Any violation sets the frame's keep_err bit. Processing continues to tlast.
- Byte count: add popcount(tkeep) per beat, saturating at 0xFFFF.
- Classification priority: keep_err → keep_err_frames; else tuser=0 → crc_err_frames; else len < MIN_BYTES → runt_frames; else len > MAX_BYTES → oversize_frames; else good_frames. Exactly one counter increments per frame. frame_good = 1 only in the good case.
- Stall:
  - In BODY, count consecutive cycles with tvalid=0. Reaching STALL_TIMEOUT sets stall_err and moves to DRAIN.
  - No counter increments and frame_done does not pulse for that frame.
- DRAIN: discard valid beats. The tlast beat returns to IDLE.
- clr_stats:
  - Zeroes all counters and stall_err. It does not affect the FSM.
  - If a frame is classified in the same cycle, clear wins and then the frame is counted: that counter ends at 1.
- Reset mid-frame: the FSM returns to IDLE. Beats arriving after release without a preceding frame start are treated as a new frame.

## Timing
- frame_done, frame_good, frame_len, frame_sig and the counters update on the edge after the tlast beat is sampled: 1-cycle latency.
- Back-to-back frames (tlast followed immediately by a new tvalid) are fully supported at one beat per clock.
- The stall counter resets on every valid beat. Timeout fires on the edge where the count reaches STALL_TIMEOUT.

## Configuration
- RX_CHK_SIGNATURE_EN defined:
  - frame_sig = rotl1(sig) XOR masked tdata per beat, where masked tdata has bytes with tkeep=0 forced to 0.
  - sig is seeded to 0 at the frame's first beat.
  - The result is registered with frame_done.
- Undefined: no signature logic is compiled in, and frame_sig is tied to 0.

## Structure
- Package rx_chk_pkg holds:
  - the FSM state encoding (IDLE/BODY/DRAIN);
  - the classification code enum (GOOD, CRC, RUNT, OVERSIZE, KEEP);
  - the LEN_W=16 constant.
- Sub-module rx_chk_beat_decode is purely combinational and parametrised by DATA_W. Given tkeep, tdata and tlast it produces popcount, keep_ok and masked tdata.

## Test plan
- 64-byte frame, 8 full beats, tuser=1 → frame_done 1 cycle after tlast, frame_good=1, frame_len=64, good_frames=1.
- 61-byte frame, last tkeep=0x1F, tuser=0 → crc_err_frames=1, frame_good=0, frame_len=61.
- 40-byte good-CRC frame → runt_frames=1. 1520-byte good-CRC frame → oversize_frames=1.
- Mid-frame beat with tkeep=0x7F, or last beat with tkeep=0x05 → keep_err_frames=1 even when tuser=0.
- tvalid low for 100 cycles inside a frame → stall_err=1, no frame_done. The remaining beats up to tlast are drained, and the next 64-byte frame → good_frames=1.
- clr_stats asserted in the cycle a good frame completes, with good_frames=5 beforehand → good_frames=1 afterwards. With the macro defined, two identical frames produce equal nonzero frame_sig.
